// File: rtl/flit_tx_fifo_80.sv
// flit_tx_fifo_80: transmit-side flit queue feeding one switch input port.
// Presents the head-of-queue flit with VALID_out, holds it while the
// downstream stall is asserted, and checks head/payload/tail/single framing
// on the enqueue side with a sticky error flag.

// Flit type field encoding; the including system may provide its own.
`ifndef FTYPEWD
`define FTYPEWD 2
`endif
`ifndef ENC_PAYL
`define ENC_PAYL 2'b00
`endif
`ifndef ENC_HEAD
`define ENC_HEAD 2'b01
`endif
`ifndef ENC_TAIL
`define ENC_TAIL 2'b10
`endif
`ifndef ENC_SING
`define ENC_SING 2'b11
`endif

module flit_tx_fifo_80 #(
    parameter int DEPTH      = 4,
    parameter int FLIT_WIDTH = 80
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_WIDTH-1:0]    FLIT_in,
    input  logic                     VALID_in,
    output logic                     STALL_out,
    output logic [FLIT_WIDTH-1:0]    FLIT_out,
    output logic                     VALID_out,
    input  logic                     STALL_in,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     in_packet,
    output logic                     framing_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_t;

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wp;
    logic [AW-1:0]         rp;
    frame_state_t          state;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [`FTYPEWD-1:0]   in_type;

    // Flow control is derived from registered occupancy only, so a full
    // queue never accepts a push in the same cycle that it pops.
    assign full      = (level == FULL_LEVEL);
    assign empty     = (level == '0);
    assign push      = VALID_in & ~full;
    // An empty queue presents nothing, so STALL_in has no effect then.
    assign pop       = ~empty & ~STALL_in;
    assign in_type   = FLIT_in[`FTYPEWD-1:0];

    assign STALL_out = full;
    assign VALID_out = ~empty;
    // Registered read: the head flit sits in storage, never bypassed from FLIT_in.
    assign FLIT_out  = mem[rp];
    assign in_packet = (state == IN_PKT);

    // Flit storage write on accepted push.
    // NOTE: the data array carries no reset; validity is tracked by level,
    // so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= FLIT_in;
        end
    end

    // Pointers and occupancy; both pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Enqueue-side framing checker; advances only on accepted pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            framing_err <= 1'b0;
        end else if (push) begin
            case (state)
                IDLE: begin
                    case (in_type)
                        `ENC_HEAD: state <= IN_PKT;
                        `ENC_SING: state <= IDLE;
                        default:   framing_err <= 1'b1;
                    endcase
                end
                IN_PKT: begin
                    case (in_type)
                        `ENC_PAYL: state <= IN_PKT;
                        `ENC_TAIL: state <= IDLE;
                        default:   framing_err <= 1'b1;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
